dcd_apply_vars: RTL and testbench

Writer side of the decision path in the SAT engine state list. Holds the per-variable value/level registers that the decision-search chain reads for free variables. Applies a chosen decision (one-hot index, polarity, level) with a req/ack handshake. Undoes assignments on backtrack by serially scanning and clearing every variable above a given level.

---
 rtl/dcd_apply_vars_if.sv | 28 ++
 rtl/dcd_apply_vars.sv | 144 ++++++++++++++
 tb/tb_dcd_apply_vars.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcd_apply_vars_if.sv
// Decision/backtrack handshake bundle between the SAT search controller and dcd_apply_vars.
// The master drives requests; the slave (the variable store) answers with ack/err/done.
interface dcd_apply_vars_if #(
   parameter int NUM   = 8,
   parameter int LVL_W = 8
);
   logic             dcd_req_i;
   logic [NUM-1:0]   dcd_index_i;
   logic             dcd_polarity_i;
   logic [LVL_W-1:0] dcd_level_i;
   logic             dcd_ack_o;
   logic             dcd_err_o;
   logic             bkt_req_i;
   logic [LVL_W-1:0] bkt_level_i;
   logic             bkt_done_o;

   modport master (
      output dcd_req_i, dcd_index_i, dcd_polarity_i, dcd_level_i,
      output bkt_req_i, bkt_level_i,
      input  dcd_ack_o, dcd_err_o, bkt_done_o
   );

   modport slave (
      input  dcd_req_i, dcd_index_i, dcd_polarity_i, dcd_level_i,
      input  bkt_req_i, bkt_level_i,
      output dcd_ack_o, dcd_err_o, bkt_done_o
   );
endinterface

// File: rtl/dcd_apply_vars.sv
// Per-variable value/level store: applies decisions and clears assignments above a level on backtrack.
// Optional DCD_APPLY_ONEHOT_CHK_EN rejects decision indexes that are not exactly one-hot.
module dcd_apply_vars #(
   parameter  int NUM   = 8,
   parameter  int WIDTH = 3,
   parameter  int LVL_W = 8,
   localparam int IDX_W = $clog2(NUM),
   localparam int CNT_W = $clog2(NUM + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dcd_apply_vars_if.slave        bus,
   output logic [NUM*WIDTH-1:0]   value_o,
   output logic [NUM*LVL_W-1:0]   level_o,
   output logic                   busy_o,
   output logic [CNT_W-1:0]       free_cnt_o
);

   typedef enum logic [1:0] {IDLE, APPLY, BKT_SCAN, BKT_DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] fields [NUM];
   logic [LVL_W-1:0] levels [NUM];
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] tgt;
   logic [LVL_W-1:0] bkt_level_q;
   logic             err_q;
   logic [CNT_W-1:0] hits;
   logic             idx_ok;
   logic             tgt_free;
   logic             dcd_write;
   logic             dcd_err_next;
   logic             scan_clear;
   logic             bkt_take;
   logic             dcd_take;
   logic [WIDTH-1:0] new_field;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.bkt_req_i) begin
               state_next = BKT_SCAN;
            end else if (bus.dcd_req_i) begin
               state_next = APPLY;
            end
         end
         APPLY:    state_next = IDLE;
         BKT_SCAN: begin
            if (ptr == IDX_W'(NUM - 1)) begin
               state_next = BKT_DONE;
            end
         end
         BKT_DONE: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o         = (state != IDLE);
      bus.dcd_ack_o  = (state == APPLY);
      bus.dcd_err_o  = (state == APPLY) && err_q;
      bus.bkt_done_o = (state == BKT_DONE);
   end

   // Target is the lowest set index bit; hits counts set bits for the optional one-hot check.
   always_comb begin
      tgt  = '0;
      hits = '0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (bus.dcd_index_i[i]) begin
            tgt  = IDX_W'(i);
            hits = hits + CNT_W'(1);
         end
      end
      tgt_free = (fields[tgt][2:1] == 2'b00);
`ifdef DCD_APPLY_ONEHOT_CHK_EN
      idx_ok       = (hits == CNT_W'(1));
      dcd_err_next = !(idx_ok && tgt_free);
`else
      idx_ok       = (hits != '0);
      dcd_err_next = idx_ok && !tgt_free;
`endif
      dcd_write  = idx_ok && tgt_free;
      new_field      = '0;
      new_field[2:1] = bus.dcd_polarity_i ? 2'b10 : 2'b01;
      scan_clear = (fields[ptr][2:1] != 2'b00) && (levels[ptr] > bkt_level_q);
      bkt_take   = (state == IDLE) && bus.bkt_req_i;
      dcd_take   = (state == IDLE) && bus.dcd_req_i && !bus.bkt_req_i;
   end

   // A decision commits on the edge entering APPLY, so the write and the ack appear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++) begin
            fields[i] <= '0;
            levels[i] <= '0;
         end
         ptr         <= '0;
         bkt_level_q <= '0;
         err_q       <= 1'b0;
      end else begin
         if (bkt_take) begin
            ptr         <= '0;
            bkt_level_q <= bus.bkt_level_i;
         end else if (dcd_take) begin
            err_q <= dcd_err_next;
            if (dcd_write) begin
               fields[tgt] <= new_field;
               levels[tgt] <= bus.dcd_level_i;
            end
         end else if (state == BKT_SCAN) begin
            if (scan_clear) begin
               fields[ptr] <= '0;
               levels[ptr] <= '0;
            end
            ptr <= ptr + IDX_W'(1);
         end
      end
   end

   always_comb begin
      value_o    = '0;
      level_o    = '0;
      free_cnt_o = '0;
      for (int i = 0; i < NUM; i++) begin
         value_o[WIDTH*i +: WIDTH] = fields[i];
         level_o[LVL_W*i +: LVL_W] = levels[i];
         if (fields[i][2:1] == 2'b00) begin
            free_cnt_o = free_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dcd_apply_vars.sv
// Randomised self-checking bench for dcd_apply_vars against an array-based model of the variable store.
module tb_dcd_apply_vars;
   localparam int NUM   = 8;
   localparam int WIDTH = 3;
   localparam int LVL_W = 8;
   localparam int CNT_W = $clog2(NUM + 1);

   logic clk = 1'b0;
   logic rst_n;
   logic [NUM*WIDTH-1:0] value_o;
   logic [NUM*LVL_W-1:0] level_o;
   logic                 busy_o;
   logic [CNT_W-1:0]     free_cnt_o;

   int errors = 0;
   int checks = 0;
   int mval [NUM];
   int mlvl [NUM];

   always #5 clk = ~clk;

   dcd_apply_vars_if #(.NUM(NUM), .LVL_W(LVL_W)) bus ();

   dcd_apply_vars #(.NUM(NUM), .WIDTH(WIDTH), .LVL_W(LVL_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .value_o(value_o),
      .level_o(level_o),
      .busy_o(busy_o),
      .free_cnt_o(free_cnt_o)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM; i++) begin
         mval[i] = 0;
         mlvl[i] = 0;
      end
   endtask

   task automatic check_state(input string tag);
      logic [NUM*WIDTH-1:0] ev;
      logic [NUM*LVL_W-1:0] el;
      int nfree;
      ev = '0;
      el = '0;
      nfree = 0;
      for (int i = 0; i < NUM; i++) begin
         ev[WIDTH*i+1 +: 2] = 2'(mval[i]);
         el[LVL_W*i +: LVL_W] = LVL_W'(mlvl[i]);
         if (mval[i] == 0) nfree++;
      end
      check_output({tag, "_value"}, 64'(value_o), 64'(ev));
      check_output({tag, "_level"}, 64'(level_o), 64'(el));
      check_output({tag, "_free"}, 64'(free_cnt_o), 64'(nfree));
   endtask

   // Decision outcome from the rules: lowest set bit is the target, only free targets are written.
   task automatic model_decide(input logic [NUM-1:0] idx, input bit pol, input int lvl, output bit exp_err);
      int nset = 0;
      int tgt = -1;
      bit ok, fr;
      for (int i = 0; i < NUM; i++) begin
         if (idx[i]) begin
            nset++;
            if (tgt < 0) tgt = i;
         end
      end
`ifdef DCD_APPLY_ONEHOT_CHK_EN
      ok = (nset == 1);
`else
      ok = (nset >= 1);
`endif
      fr = ok && (mval[tgt] == 0);
`ifdef DCD_APPLY_ONEHOT_CHK_EN
      exp_err = !fr;
`else
      exp_err = ok && !fr;
`endif
      if (fr) begin
         mval[tgt] = pol ? 2 : 1;
         mlvl[tgt] = lvl;
      end
   endtask

   task automatic model_backtrack(input int lvl);
      for (int i = 0; i < NUM; i++) begin
         if (mval[i] != 0 && mlvl[i] > lvl) begin
            mval[i] = 0;
            mlvl[i] = 0;
         end
      end
   endtask

   // Entered and left #1 after a rising edge with the DUT idle.
   task automatic apply_stimulus(input bit is_bkt, input logic [NUM-1:0] idx, input bit pol, input int lvl);
      bit exp_err;
      int cycles;
      if (!is_bkt) begin
         bus.dcd_req_i      = 1'b1;
         bus.dcd_index_i    = idx;
         bus.dcd_polarity_i = pol;
         bus.dcd_level_i    = LVL_W'(lvl);
         check_output("dcd_pre_ack", 64'(bus.dcd_ack_o), 64'd0);
         model_decide(idx, pol, lvl, exp_err);
         @(posedge clk); #1;
         check_output("dcd_ack", 64'(bus.dcd_ack_o), 64'd1);
         check_output("dcd_err", 64'(bus.dcd_err_o), 64'(exp_err));
         check_state("dcd");
         bus.dcd_req_i = 1'b0;
         @(posedge clk); #1;
         check_output("dcd_ack_pulse", 64'(bus.dcd_ack_o), 64'd0);
         check_output("dcd_idle", 64'(busy_o), 64'd0);
      end else begin
         bus.bkt_req_i   = 1'b1;
         bus.bkt_level_i = LVL_W'(lvl);
         cycles = 0;
         for (int c = 1; c <= NUM + 4; c++) begin
            @(posedge clk); #1;
            check_output("bkt_busy", 64'(busy_o), 64'd1);
            if (bus.bkt_done_o) begin
               cycles = c;
               break;
            end
         end
         check_output("bkt_latency", 64'(cycles), 64'(NUM + 1));
         bus.bkt_req_i = 1'b0;
         model_backtrack(lvl);
         check_state("bkt");
         @(posedge clk); #1;
         check_output("bkt_done_pulse", 64'(bus.bkt_done_o), 64'd0);
         check_output("bkt_idle", 64'(busy_o), 64'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_state(tag);
      check_output({tag, "_busy"}, 64'(busy_o), 64'd0);
      check_output({tag, "_ack"}, 64'(bus.dcd_ack_o), 64'd0);
      check_output({tag, "_err"}, 64'(bus.dcd_err_o), 64'd0);
      check_output({tag, "_done"}, 64'(bus.bkt_done_o), 64'd0);
   endtask

   initial begin
      bit exp_err;
      int cycles;
      logic [NUM-1:0] idx;
      int r;

      rst_n              = 1'b0;
      bus.dcd_req_i      = 1'b0;
      bus.dcd_index_i    = '0;
      bus.dcd_polarity_i = 1'b0;
      bus.dcd_level_i    = '0;
      bus.bkt_req_i      = 1'b0;
      bus.bkt_level_i    = '0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(1'b0, 8'b0001_0001, 1'b0, 1);
      apply_stimulus(1'b0, 8'b0000_0100, 1'b1, 3);
      apply_stimulus(1'b0, 8'b0000_0100, 1'b0, 5);
      apply_stimulus(1'b0, 8'b0000_0001, 1'b1, 1);
      apply_stimulus(1'b0, 8'b0010_0000, 1'b1, 4);
      apply_stimulus(1'b1, '0, 1'b0, 2);

      // Simultaneous requests: backtrack first, then the held decision acks two cycles after done.
      bus.dcd_req_i      = 1'b1;
      bus.dcd_index_i    = 8'b0000_1000;
      bus.dcd_polarity_i = 1'b1;
      bus.dcd_level_i    = 8'd2;
      bus.bkt_req_i      = 1'b1;
      bus.bkt_level_i    = 8'd0;
      cycles = 0;
      for (int c = 1; c <= NUM + 4; c++) begin
         @(posedge clk); #1;
         check_output("sim_no_ack", 64'(bus.dcd_ack_o), 64'd0);
         if (bus.bkt_done_o) begin
            cycles = c;
            break;
         end
      end
      check_output("sim_bkt_latency", 64'(cycles), 64'(NUM + 1));
      bus.bkt_req_i = 1'b0;
      model_backtrack(0);
      model_decide(8'b0000_1000, 1'b1, 2, exp_err);
      cycles = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (bus.dcd_ack_o) begin
            cycles = c;
            break;
         end
      end
      check_output("sim_ack_latency", 64'(cycles), 64'd2);
      check_output("sim_err", 64'(bus.dcd_err_o), 64'(exp_err));
      check_state("sim");
      bus.dcd_req_i = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a scan discards it with no done pulse.
      apply_stimulus(1'b0, 8'b0100_0000, 1'b0, 2);
      bus.bkt_req_i   = 1'b1;
      bus.bkt_level_i = 8'd0;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.bkt_req_i = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midrst");
      repeat (2) begin
         @(posedge clk); #1;
         check_output("midrst_no_done", 64'(bus.bkt_done_o), 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("postrst");

      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            apply_stimulus(1'b1, '0, 1'b0, $urandom_range(0, 12));
         end else begin
            r = $urandom_range(0, 9);
            if (r < 7) idx = NUM'(1) << $urandom_range(0, NUM - 1);
            else if (r < 9) idx = NUM'($urandom);
            else idx = '0;
            apply_stimulus(1'b0, idx, 1'($urandom), $urandom_range(0, 12));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
